// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_stage                                                     |
// | Purpose  : RV32I memory-access stage. Issues load/store requests on a    |
// |            valid/ready request + valid response data-memory interface,   |
// |            lane-aligns store data/strobes, right-justifies load data,    |
// |            holds the MEM/WB register and stalls upstream while a memory  |
// |            transaction is outstanding.                                   |
// | Ports    : clk/reset (sync, active-high); in_* EX/MEM slot; stall_mem    |
// |            to upstream; dmem_* request/response; wb_* MEM/WB register.   |
// | Options  : MISALIGN_TRAP_EN - misaligned lh/lhu/sh/lw/sw issue no        |
// |            request and retire with wb_exc=1. Undefined: wb_exc tied 0.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu_res,
  input  logic [31:0] in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic        in_load,
  input  logic        in_store,
  input  logic        in_jal,
  input  logic        in_reg_write,
  input  logic [4:0]  in_rd,
  output logic        stall_mem,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_data,
  output logic        wb_valid,
  output logic        wb_load,
  output logic        wb_jal,
  output logic        wb_reg_write,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_alu_res,
  output logic [31:0] wb_mdata,
  output logic [2:0]  wb_funct3,
  output logic [4:0]  wb_rd,
  output logic        wb_exc
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state, state_next;

  logic       mem_op;
  logic [1:0] lane;
  logic       trap;
  logic       wb_fire;
  logic       load_done;

  assign mem_op = in_valid & (in_load | in_store);
  assign lane   = in_alu_res[1:0];

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  // funct3[1:0]: 00 byte, 01 half, 10 word
  assign misaligned = ((in_funct3[1:0] == 2'b01) & lane[0]) |
                      ((in_funct3[1:0] == 2'b10) & (lane != 2'b00));
  assign trap = mem_op & misaligned & (state == S_IDLE);
`else
  assign trap = 1'b0;
`endif

  // Next state and handshake control
  always_comb begin
    state_next     = state;
    dmem_req_valid = 1'b0;
    stall_mem      = 1'b0;
    wb_fire        = 1'b0;
    load_done      = 1'b0;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          if (trap) begin
            wb_fire = 1'b1;
          end else if (mem_op) begin
            dmem_req_valid = 1'b1;
            // A store finishes in its handshake cycle, so upstream may advance.
            stall_mem = !(in_store && dmem_req_ready);
            if (dmem_req_ready) begin
              if (in_store) wb_fire = 1'b1;
              else          state_next = S_WAIT;
            end
          end else if (in_valid) begin
            wb_fire = 1'b1;
          end
        end
        S_WAIT: begin
          stall_mem = 1'b1;
          if (dmem_rsp_valid) begin
            // Upstream still holds the load's in_* this cycle; release it now.
            stall_mem  = 1'b0;
            wb_fire    = 1'b1;
            load_done  = 1'b1;
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Store lane replication and byte strobes
  assign dmem_we   = in_store;
  assign dmem_addr = {in_alu_res[31:2], 2'b00};

  always_comb begin
    dmem_wdata = in_rs2;
    dmem_wstrb = 4'hF;
    case (in_funct3[1:0])
      2'b00: begin
        dmem_wdata = {4{in_rs2[7:0]}};
        dmem_wstrb = 4'b0001 << lane;
      end
      2'b01: begin
        dmem_wdata = {2{in_rs2[15:0]}};
        // 4-bit result drops strobes past byte 3 (misaligned truncation)
        dmem_wstrb = 4'b0011 << lane;
      end
      default: begin
        dmem_wdata = in_rs2;
        dmem_wstrb = 4'hF;
      end
    endcase
    if (!in_store) dmem_wstrb = 4'h0;
  end

  // State register and MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      wb_valid     <= 1'b0;
      wb_load      <= 1'b0;
      wb_jal       <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_pc        <= 32'h0;
      wb_alu_res   <= 32'h0;
      wb_mdata     <= 32'h0;
      wb_funct3    <= 3'h0;
      wb_rd        <= 5'h0;
      wb_exc       <= 1'b0;
    end else begin
      state    <= state_next;
      wb_valid <= wb_fire;
      if (wb_fire) begin
        wb_load      <= in_load;
        wb_jal       <= in_jal;
        wb_reg_write <= in_reg_write & ~in_store & ~trap;
        wb_pc        <= in_pc;
        wb_alu_res   <= in_alu_res;
        wb_mdata     <= load_done ? (dmem_rsp_data >> {lane, 3'b000}) : 32'h0;
        wb_funct3    <= in_funct3;
        wb_rd        <= in_rd;
        wb_exc       <= trap;
      end
    end
  end

endmodule
`default_nettype wire
